// File: rtl/uart_char_rx_if.sv
// Serial-in / character-out bundle between the UART receiver and its consumer.
// Ports: rx (serial line, idles high), char_out (last good character),
//        enter (fixed-width strobe per good frame), frame_err (sticky bad-stop flag).
interface uart_char_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx;
  logic [DATA_WIDTH-1:0] char_out;
  logic                  enter;
  logic                  frame_err;

  // master: the receiver; slave: the line driver / character consumer
  modport master (input rx, output char_out, output enter, output frame_err);
  modport slave  (output rx, input char_out, input enter, input frame_err);
endinterface

// File: rtl/uart_char_rx.sv
// 8N1-style UART receiver producing a held character plus an enter strobe.
// Ports: clk, reset_n (synchronous, active-low), bus (uart_char_rx_if.master).
// Latency: rx fall to enter rise = 2 + HALF + (DATA_WIDTH+1)*CLKS_PER_BIT cycles; no backpressure.
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int ENTER_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_char_rx_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_WIDTH + 1);
  localparam int EW   = $clog2(ENTER_CYCLES + 1);

  localparam logic [CW-1:0] CNT_HALF   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_WIDTH - 1);
  localparam logic [EW-1:0] ENTER_LOAD = EW'(ENTER_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic                  rx_m, rx_s;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] char_q;
  logic                  err_q;
  logic [EW-1:0]         enter_cnt;

  logic half_hit, bit_hit, last_bit;
  logic cnt_clr, cnt_inc, idx_clr, shift_en, frame_ok, frame_bad;

  assign half_hit = (cnt == CNT_HALF);
  assign bit_hit  = (cnt == CNT_LAST);
  assign last_bit = (idx == IDX_LAST);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && last_bit) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = rx_s ? IDLE : BRK;
      // A held-low line must go high before a new start bit can count.
      BRK:     if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      START: begin
        if (half_hit) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (bit_hit) begin
          cnt_clr   = 1'b1;
          frame_ok  = rx_s;
          frame_bad = !rx_s;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      idx       <= '0;
      sreg      <= '0;
      char_q    <= '0;
      err_q     <= 1'b0;
      enter_cnt <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (idx_clr)       idx <= '0;
      else if (shift_en) idx <= idx + 1'b1;

      // LSB arrives first, so bits enter at the MSB and walk down to bit 0.
      if (shift_en) sreg <= {rx_s, sreg[DATA_WIDTH-1:1]};

      // The enter counter runs independently so the FSM can take the next
      // start bit while the strobe is still high.
      if (frame_ok) begin
        char_q    <= sreg;
        err_q     <= 1'b0;
        enter_cnt <= ENTER_LOAD;
      end else begin
        if (frame_bad)        err_q     <= 1'b1;
        if (enter_cnt != '0)  enter_cnt <= enter_cnt - 1'b1;
      end
    end
  end

  assign bus.char_out  = char_q;
  assign bus.frame_err = err_q;
  assign bus.enter     = (enter_cnt != '0);

endmodule

// File: doc/uart_char_rx.md
# uart_char_rx

UART receiver that turns a serial 8N1 byte stream into a parallel character plus an `enter` strobe for the password lock FSM directly downstream. Each correctly framed byte updates `char_out`, which then holds steady, and produces a fixed-width `enter` pulse. The downstream FSM waits for `enter` to be released, then samples `char_out`. Bad frames raise `frame_err` and never produce `enter`.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200). Legal range ≥ 4.
- `DATA_WIDTH`, default 8: data bits per frame, sent LSB first. Must match the downstream character width.
- `ENTER_CYCLES`, default 4: width of the `enter` pulse in clk cycles. Legal range 1 ≤ ENTER_CYCLES < CLKS_PER_BIT.

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, synchronous, active-low. Clock is `clk`.
- `rx`  in  1: asynchronous serial line, idles high.
- `char_out`  out  DATA_WIDTH: last correctly framed character.
- `enter`  out  1: high for exactly ENTER_CYCLES cycles after each good frame.
- `frame_err`  out  1: sticky; set on a bad stop bit, cleared by the next good frame.

## Operation

- `rx` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_s`. All logic below uses `rx_s` only.
- `HALF` = CLKS_PER_BIT/2, integer division.
- The bit-timing counter is wide enough to hold CLKS_PER_BIT-1. The bit index is ceil(log2(DATA_WIDTH+1)) bits wide.
- FSM states and transitions:
  - **IDLE**: counter held at 0. If `rx_s`==0, go to START.
  - **START**: count up. When the count reaches HALF-1, sample `rx_s`:
    - 0: go to DATA, clear counter and bit index.
    - 1: treat as a glitch and return to IDLE. No output changes.
  - **DATA**: count to CLKS_PER_BIT-1, then sample `rx_s`. Shift it in LSB-first (shift register fills from the MSB end toward bit 0), clear the counter and increment the index. After the DATA_WIDTH-th sample, go to STOP.
  - **STOP**: count to CLKS_PER_BIT-1, then sample `rx_s`:
    - 1 (good frame): load `char_out` from the shift register, clear `frame_err`, load the enter counter with ENTER_CYCLES, go to IDLE.
    - 0 (bad frame): set `frame_err`, leave `char_out` unchanged, go to BREAK.
  - **BREAK**: wait for `rx_s`==1, then go to IDLE. A held-low line (break) never starts a new frame.
- `enter` is driven by a separate down-counter, so the FSM is back in IDLE and able to catch the next start bit while `enter` is still high.
  - `enter` = 1 while the counter is nonzero.
  - The counter decrements each cycle.
  - If a new good frame completes while the counter is nonzero, it reloads to ENTER_CYCLES. This is unreachable within the legal parameter range, but it is defined behaviour.
- `char_out` is stable from the load cycle until the next good frame. It is therefore valid throughout `enter` and after `enter` falls.
- Reset (`reset_n`==0 at a clk edge) has priority over all other logic:
  - state → IDLE; counters, bit index and shift register → 0; synchronizer flops → 1.
  - `char_out` = 0, `enter` = 0, `frame_err` = 0.
  - Reset mid-frame aborts the frame. No `enter` pulse follows, and the next frame needs a fresh falling edge.

## Timing

- Let T be the first clk edge at which `rx_s` is 0 while in IDLE.
  - START is entered at T+1.
  - Start-bit sample at T+HALF.
  - Data bit k (k = 0..DATA_WIDTH-1) sampled at T+HALF+(k+1)·CLKS_PER_BIT.
  - Stop-bit sample at T+HALF+(DATA_WIDTH+1)·CLKS_PER_BIT.
- Outputs on a good frame: `char_out`, `frame_err` and `enter` change at the stop-sample edge, i.e. they are visible the cycle after the sample. `enter` is high for exactly ENTER_CYCLES cycles.
- Latency from the `rx` pin falling edge to `enter` rising: 2 (synchronizer) + HALF + (DATA_WIDTH+1)·CLKS_PER_BIT cycles, ±1.
- Back-to-back frames:
  - A start bit arriving immediately after the stop bit must be caught.
  - IDLE is re-entered within 1 cycle of the stop sample.
  - Any stop bit of at least HALF+2 cycles is sufficient.
- Sampling tolerance: ±(HALF-2) cycles of accumulated drift per frame.

## Test plan

Bench parameters: CLKS_PER_BIT=16, ENTER_CYCLES=4.

1. **Reset.** Hold `reset_n`=0 for 3 cycles with `rx`=1 → `char_out`=0x00, `enter`=0, `frame_err`=0. Then send 0x48 ("H") → `char_out`=0x48, `enter` high exactly 4 cycles, `frame_err`=0.
2. **Back-to-back frames.** Send 0x48 then 0xA5 with a 1-bit stop and no idle between them → two `enter` pulses; `char_out` = 0x48, then 0xA5. Check bit order by sending 0x01: it must not read back as 0x80.
3. **Glitch.** Drive `rx` low for 5 cycles (less than HALF=8), then high → no `enter`, `char_out` and `frame_err` unchanged. A following valid 0x3C is received correctly.
4. **Framing error.** Send 0x55 with stop bit 0, keep `rx` low for 40 cycles, then release → `frame_err`=1, no `enter`, `char_out` keeps its previous value, and no frame starts during the low period. The next valid 0x41 → `frame_err`=0, `char_out`=0x41, one `enter` pulse.
5. **Reset mid-frame.** Assert reset during data bit 3 of 0xFF, then release with `rx`=1 → all outputs 0, no `enter`. The next 0x12 is received correctly.
6. **Downstream handshake.** Connect to the password FSM with PASSWORD=0x48. Send 0x48 → `open`=1. After a reset, send 0x47 → `wrong`=1, `open`=0.
